bcd_scan_conv: RTL and testbench

//  Parametrised multi-channel binary-to-BCD converter for the display path.

---
 rtl/bcd_scan_conv.sv | 133 +++++++++++++
 tb/tb_bcd_scan_conv.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_conv.sv
// Multi-channel binary-to-BCD converter for the display path.
// One double-dabble engine, one bit per cycle, shared round-robin across channels.
module bcd_scan_conv #(
    parameter int WIDTH     = 12,
    parameter int N_DIG     = 4,
    parameter int N_CH      = 2,
    parameter int AUTO_SCAN = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    start,
    input  logic [N_CH*WIDTH-1:0]   bin_in,
    output logic [N_CH*N_DIG*4-1:0] bcd_out,
    output logic [N_CH-1:0]         ovf,
    output logic [N_CH-1:0]         upd,
    output logic                    busy,
    output logic                    done
);

    localparam int N_INT = (WIDTH + 2) / 3;
    localparam int N_EXT = (N_DIG > N_INT) ? N_DIG : N_INT;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int DW    = N_DIG * 4;
    localparam bit AUTO  = (AUTO_SCAN != 0);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        STORE
    } state_t;

    state_t state, state_nx;

    logic [CH_W-1:0]    ch;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   shreg;
    logic [N_INT*4-1:0] scratch;
    logic [N_INT*4-1:0] adj;
    logic [N_EXT*4-1:0] ext;
    logic [DW-1:0]      res;
    logic               sat;
    logic               go;
    logic               more;

    assign go   = (AUTO && en) || (!AUTO && start);
    assign more = (AUTO && en) || (!AUTO && (ch != LAST_CH));

    always_comb begin
        adj = scratch;
        for (int i = 0; i < N_INT; i++) begin
            if (scratch[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Widen scratch to cover the presented digits; any digit above them saturates.
    always_comb begin
        ext = '0;
        ext[N_INT*4-1:0] = scratch;
        sat = 1'b0;
        for (int i = N_DIG; i < N_EXT; i++) begin
            if (ext[i*4 +: 4] != 4'd0) begin
                sat = 1'b1;
            end
        end
        res = sat ? {N_DIG{4'h9}} : ext[DW-1:0];
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (go) state_nx = LOAD;
            LOAD:    state_nx = SHIFT;
            SHIFT:   if (cnt == CNT_W'(1)) state_nx = STORE;
            STORE:   state_nx = more ? LOAD : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch      <= '0;
            cnt     <= '0;
            shreg   <= '0;
            scratch <= '0;
            bcd_out <= '0;
            ovf     <= '0;
            upd     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            upd  <= '0;
            done <= 1'b0;
            busy <= (state_nx != IDLE);
            unique case (state)
                IDLE: begin
                    ch <= '0;
                end
                LOAD: begin
                    shreg   <= bin_in[ch*WIDTH +: WIDTH];
                    scratch <= '0;
                    cnt     <= CNT_W'(WIDTH);
                end
                SHIFT: begin
                    {scratch, shreg} <= {adj, shreg} << 1;
                    cnt <= cnt - 1'b1;
                end
                STORE: begin
                    bcd_out[ch*DW +: DW] <= res;
                    ovf[ch]  <= sat;
                    upd[ch]  <= 1'b1;
                    done     <= (ch == LAST_CH);
                    ch       <= (ch == LAST_CH) ? '0 : ch + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_scan_conv.sv
// Scoreboard bench for bcd_scan_conv: four configurations share clock and reset.
// Stimulus pushes expected updates; a negedge monitor pops and compares them.
module tb_bcd_scan_conv;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        start_a, start_bd, en_c;
    logic [23:0] bin_a, bin_b, bin_c;
    logic [47:0] bin_d;

    logic [31:0] bcd_a, bcd_c;
    logic [23:0] bcd_b;
    logic [59:0] bcd_d;
    logic [1:0]  ovf_a, ovf_b, ovf_c, upd_a, upd_b, upd_c;
    logic [2:0]  ovf_d, upd_d;
    logic        busy_a, busy_b, busy_c, busy_d;
    logic        done_a, done_b, done_c, done_d;

    bcd_scan_conv #(.WIDTH(12), .N_DIG(4), .N_CH(2), .AUTO_SCAN(0)) u_a (
        .clk(clk), .rst_n(rst_n), .en(1'b0), .start(start_a),
        .bin_in(bin_a), .bcd_out(bcd_a), .ovf(ovf_a), .upd(upd_a),
        .busy(busy_a), .done(done_a)
    );

    bcd_scan_conv #(.WIDTH(12), .N_DIG(3), .N_CH(2), .AUTO_SCAN(0)) u_b (
        .clk(clk), .rst_n(rst_n), .en(1'b0), .start(start_bd),
        .bin_in(bin_b), .bcd_out(bcd_b), .ovf(ovf_b), .upd(upd_b),
        .busy(busy_b), .done(done_b)
    );

    bcd_scan_conv #(.WIDTH(12), .N_DIG(4), .N_CH(2), .AUTO_SCAN(1)) u_c (
        .clk(clk), .rst_n(rst_n), .en(en_c), .start(1'b0),
        .bin_in(bin_c), .bcd_out(bcd_c), .ovf(ovf_c), .upd(upd_c),
        .busy(busy_c), .done(done_c)
    );

    bcd_scan_conv #(.WIDTH(16), .N_DIG(5), .N_CH(3), .AUTO_SCAN(0)) u_d (
        .clk(clk), .rst_n(rst_n), .en(1'b0), .start(start_bd),
        .bin_in(bin_d), .bcd_out(bcd_d), .ovf(ovf_d), .upd(upd_d),
        .busy(busy_d), .done(done_d)
    );

    typedef struct {
        int          inst;
        int          ch;
        logic [19:0] bcd;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   done_cnt[4] = '{0, 0, 0, 0};

    function automatic void expect_upd(int inst, int c, logic [19:0] bcd,
                                       logic ov, int at);
        exp_t e;
        e.inst = inst;
        e.ch   = c;
        e.bcd  = bcd;
        e.ovf  = ov;
        e.cyc  = at;
        sb.push_back(e);
    endfunction

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endfunction

    function automatic void check_upd(int inst, int c, logic [19:0] bcd, logic ov);
        int   idx[$];
        exp_t e;
        tests++;
        idx = sb.find_first_index(x) with (x.inst == inst && x.ch == c);
        if (idx.size() == 0) begin
            fails++;
            $display("FAIL upd u%0d ch%0d: unexpected update bcd=%h ovf=%b cyc=%0d",
                     inst, c, bcd, ov, cyc);
        end else begin
            e = sb[idx[0]];
            sb.delete(idx[0]);
            if (bcd !== e.bcd || ov !== e.ovf || cyc != e.cyc) begin
                fails++;
                $display("FAIL upd u%0d ch%0d: got bcd=%h ovf=%b cyc=%0d, want bcd=%h ovf=%b cyc=%0d",
                         inst, c, bcd, ov, cyc, e.bcd, e.ovf, e.cyc);
            end
        end
    endfunction

    function automatic void check_done(int inst, logic d, logic last_upd);
        if (d || last_upd) begin
            tests++;
            if (d !== last_upd) begin
                fails++;
                $display("FAIL done u%0d: got done=%b, want %b (upd of last ch)",
                         inst, d, last_upd);
            end
        end
        if (d) done_cnt[inst]++;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            for (int c = 0; c < 2; c++) begin
                if (upd_a[c]) check_upd(0, c, 20'(bcd_a[c*16 +: 16]), ovf_a[c]);
                if (upd_b[c]) check_upd(1, c, 20'(bcd_b[c*12 +: 12]), ovf_b[c]);
                if (upd_c[c]) check_upd(2, c, 20'(bcd_c[c*16 +: 16]), ovf_c[c]);
            end
            for (int c = 0; c < 3; c++) begin
                if (upd_d[c]) check_upd(3, c, bcd_d[c*20 +: 20], ovf_d[c]);
            end
            check_done(0, done_a, upd_a[1]);
            check_done(1, done_b, upd_b[1]);
            check_done(2, done_c, upd_c[1]);
            check_done(3, done_d, upd_d[2]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int k;

    initial begin
        start_a  = 1'b0;
        start_bd = 1'b0;
        en_c     = 1'b0;
        bin_a    = '0;
        bin_b    = '0;
        bin_c    = '0;
        bin_d    = '0;
        repeat (3) tick();
        chk("reset bcd_a", 64'(bcd_a), 64'd0);
        chk("reset ovf_a", 64'(ovf_a), 64'd0);
        chk("reset busy_a", 64'(busy_a), 64'd0);
        chk("reset done_a", 64'(done_a), 64'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // One-shot sweeps: basic conversion, saturation and wide channels
        bin_a = {12'd0, 12'd1234};
        bin_b = {12'd999, 12'd4095};
        bin_d = {16'd12345, 16'd40000, 16'd65535};
        start_a  = 1'b1;
        start_bd = 1'b1;
        k = cyc;
        expect_upd(0, 0, 20'h01234, 1'b0, k + 15);
        expect_upd(0, 1, 20'h00000, 1'b0, k + 29);
        expect_upd(1, 0, 20'h00999, 1'b1, k + 15);
        expect_upd(1, 1, 20'h00999, 1'b0, k + 29);
        expect_upd(3, 0, 20'h65535, 1'b0, k + 19);
        expect_upd(3, 1, 20'h40000, 1'b0, k + 37);
        expect_upd(3, 2, 20'h12345, 1'b0, k + 55);
        tick();
        start_a  = 1'b0;
        start_bd = 1'b0;
        repeat (5) tick();
        bin_a[11:0] = 12'd66;
        chk("busy_a mid sweep", 64'(busy_a), 64'd1);
        repeat (60) tick();
        chk("busy_a after sweep", 64'(busy_a), 64'd0);
        chk("busy_b after sweep", 64'(busy_b), 64'd0);
        chk("busy_d after sweep", 64'(busy_d), 64'd0);
        chk("done count a", 64'(done_cnt[0]), 64'd1);
        chk("done count d", 64'(done_cnt[3]), 64'd1);

        // Start pulses during a sweep are dropped
        bin_a = {12'd10, 12'd4095};
        bin_d = {16'd59999, 16'd10000, 16'd9};
        start_a  = 1'b1;
        start_bd = 1'b1;
        k = cyc;
        expect_upd(0, 0, 20'h04095, 1'b0, k + 15);
        expect_upd(0, 1, 20'h00010, 1'b0, k + 29);
        expect_upd(1, 0, 20'h00999, 1'b1, k + 15);
        expect_upd(1, 1, 20'h00999, 1'b0, k + 29);
        expect_upd(3, 0, 20'h00009, 1'b0, k + 19);
        expect_upd(3, 1, 20'h10000, 1'b0, k + 37);
        expect_upd(3, 2, 20'h59999, 1'b0, k + 55);
        for (int i = 1; i <= 30; i++) begin
            tick();
            start_bd = 1'b0;
            start_a  = (i == 5 || i == 20);
        end
        repeat (5) tick();
        chk("busy_a after ignored starts", 64'(busy_a), 64'd0);
        chk("done count a single sweep", 64'(done_cnt[0]), 64'd2);

        bin_a = {12'd100, 12'd9};
        start_a = 1'b1;
        k = cyc;
        expect_upd(0, 0, 20'h00009, 1'b0, k + 15);
        expect_upd(0, 1, 20'h00100, 1'b0, k + 29);
        tick();
        start_a = 1'b0;
        repeat (32) tick();
        chk("done count a new sweep", 64'(done_cnt[0]), 64'd3);
        chk("busy_d idle", 64'(busy_d), 64'd0);

        // Reset in the middle of a conversion
        bin_a = {12'd777, 12'd1234};
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (5) tick();
        chk("busy_a before reset", 64'(busy_a), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid reset bcd_a", 64'(bcd_a), 64'd0);
        chk("mid reset ovf_a", 64'(ovf_a), 64'd0);
        chk("mid reset upd_a", 64'(upd_a), 64'd0);
        chk("mid reset busy_a", 64'(busy_a), 64'd0);
        chk("mid reset done_a", 64'(done_a), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        chk("busy_a after reset", 64'(busy_a), 64'd0);
        chk("bcd_a after reset", 64'(bcd_a), 64'd0);

        // Auto scan: input sampled only at load, en drop finishes current channel
        bin_c = {12'd42, 12'd4095};
        en_c  = 1'b1;
        k = cyc;
        expect_upd(2, 0, 20'h04095, 1'b0, k + 15);
        expect_upd(2, 1, 20'h00042, 1'b0, k + 29);
        expect_upd(2, 0, 20'h00007, 1'b0, k + 43);
        repeat (4) tick();
        bin_c[11:0] = 12'd7;
        repeat (31) tick();
        en_c = 1'b0;
        repeat (20) tick();
        chk("busy_c after en drop", 64'(busy_c), 64'd0);
        chk("done count c", 64'(done_cnt[2]), 64'd1);

        chk("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
